// File: rtl/sc_level_sequencer.sv
// Level sequencer for the background-type register: issues load-pattern / load-init commands
// and runs the game flow. Define SC_LEVELSEQ_WRAP_EN to wrap past MAX_LEVEL instead of winning.
module sc_level_sequencer #(
  parameter logic [7:0]  DATA_INIT_PATTERN = 8'b11100111,
  parameter logic [3:0]  MAX_LEVEL         = 4'd7,
  parameter int unsigned HOLDOFF_CYCLES    = 16
) (
  input  logic       SC_LevelSeq_CLOCK_50,
  input  logic       SC_LevelSeq_RESET_InHigh,
  input  logic       SC_LevelSeq_START_InLow,
  input  logic       SC_LevelSeq_LEVELDONE,
  input  logic       SC_LevelSeq_CRASH,
  output logic [3:0] SC_LevelSeq_NEXTLEVEL_OutBUS,
  output logic [7:0] SC_LevelSeq_LEVELOR_OutBUS,
  output logic [3:0] SC_LevelSeq_LEVEL_OutBUS,
  output logic       SC_LevelSeq_BUSY,
  output logic       SC_LevelSeq_WIN,
  output logic       SC_LevelSeq_GAMEOVER
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_ADVANCE = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_PLAY    = 3'd4;
  localparam logic [2:0] S_WIN     = 3'd5;

  localparam logic [3:0] CMD_HOLD = 4'b0000;
  localparam logic [3:0] CMD_LOAD = 4'b0001;
  localparam logic [3:0] CMD_INIT = 4'b0010;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES);

  logic [2:0] state;
  logic [7:0] holdCnt;
  logic [7:0] pattern;
  logic [3:0] level;
  logic [3:0] nextLevel;
  logic       busy, win, gameOver;

  logic doInit, doCrash, doAdvance, doWin, atTop;

  assign atTop = (level >= MAX_LEVEL);

  // Crash has priority over LEVELDONE; INIT is a single cycle and ignores both.
  always_comb begin
    doInit    = 1'b0;
    doCrash   = 1'b0;
    doAdvance = 1'b0;
    doWin     = 1'b0;
    if ((state == S_IDLE || state == S_WIN) && !SC_LevelSeq_START_InLow)
      doInit = 1'b1;
    else if (SC_LevelSeq_CRASH &&
             (state == S_PLAY || state == S_ADVANCE || state == S_SETTLE))
      doCrash = 1'b1;
    else if (state == S_PLAY && SC_LevelSeq_LEVELDONE) begin
`ifdef SC_LEVELSEQ_WRAP_EN
      doAdvance = 1'b1;
`else
      doAdvance = !atTop;
      doWin     = atTop;
`endif
    end
  end

  always_ff @(posedge SC_LevelSeq_CLOCK_50 or posedge SC_LevelSeq_RESET_InHigh) begin
    if (SC_LevelSeq_RESET_InHigh) begin
      state     <= S_IDLE;
      holdCnt   <= 8'd0;
      pattern   <= DATA_INIT_PATTERN;
      level     <= 4'd0;
      nextLevel <= CMD_HOLD;
      busy      <= 1'b0;
      win       <= 1'b0;
      gameOver  <= 1'b0;
    end else begin
      nextLevel <= CMD_HOLD;
      if (doInit) begin
        state     <= S_INIT;
        nextLevel <= CMD_INIT;
        level     <= 4'd0;
        pattern   <= DATA_INIT_PATTERN;
        gameOver  <= 1'b0;
        win       <= 1'b0;
      end else if (doCrash) begin
        state     <= S_IDLE;
        nextLevel <= CMD_INIT;
        level     <= 4'd0;
        pattern   <= DATA_INIT_PATTERN;
        gameOver  <= 1'b1;
        busy      <= 1'b0;
        holdCnt   <= 8'd0;
      end else if (doAdvance) begin
        // Rotation continues across a level wrap; eight rotations return to the init pattern.
        state     <= S_ADVANCE;
        nextLevel <= CMD_LOAD;
        pattern   <= {pattern[6:0], pattern[7]};
        level     <= atTop ? 4'd0 : level + 4'd1;
        busy      <= 1'b1;
      end else if (doWin) begin
        state <= S_WIN;
        win   <= 1'b1;
      end else begin
        case (state)
          S_INIT, S_ADVANCE: begin
            state   <= S_SETTLE;
            holdCnt <= HOLD_LOAD;
            busy    <= 1'b1;
          end
          S_SETTLE: begin
            if (holdCnt <= 8'd1) begin
              state   <= S_PLAY;
              holdCnt <= 8'd0;
              busy    <= 1'b0;
            end else begin
              holdCnt <= holdCnt - 8'd1;
            end
          end
          S_IDLE, S_PLAY, S_WIN: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign SC_LevelSeq_NEXTLEVEL_OutBUS = nextLevel;
  assign SC_LevelSeq_LEVELOR_OutBUS   = pattern;
  assign SC_LevelSeq_LEVEL_OutBUS     = level;
  assign SC_LevelSeq_BUSY             = busy;
  assign SC_LevelSeq_WIN              = win;
  assign SC_LevelSeq_GAMEOVER         = gameOver;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Bench for sc_level_sequencer: directed game-flow steps followed by random play, checked
// cycle by cycle against a rule-level model (pattern derived from level by rotation).
module tb_sc_level_sequencer;

  localparam logic [7:0] INIT_PAT = 8'b11100111;
  localparam int         MAXL     = 7;
  localparam int         HOLD     = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       startN = 1'b1;
  logic       ld = 1'b0;
  logic       cr = 1'b0;
  logic [3:0] cmd;
  logic [7:0] lvlOr;
  logic [3:0] lvl;
  logic       busy, win, gover;

  int checks = 0;
  int failures = 0;

  // model state
  bit active, initCycle, mWin, mGo, mBusy;
  int mLevel, pending;
  logic [3:0] mCmd;

  sc_level_sequencer dut (
    .SC_LevelSeq_CLOCK_50        (clk),
    .SC_LevelSeq_RESET_InHigh    (rst),
    .SC_LevelSeq_START_InLow     (startN),
    .SC_LevelSeq_LEVELDONE       (ld),
    .SC_LevelSeq_CRASH           (cr),
    .SC_LevelSeq_NEXTLEVEL_OutBUS(cmd),
    .SC_LevelSeq_LEVELOR_OutBUS  (lvlOr),
    .SC_LevelSeq_LEVEL_OutBUS    (lvl),
    .SC_LevelSeq_BUSY            (busy),
    .SC_LevelSeq_WIN             (win),
    .SC_LevelSeq_GAMEOVER        (gover)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] p, input int n);
    logic [7:0] r;
    r = p;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".cmd"},   {4'd0, cmd},  {4'd0, mCmd});
    chk({tag, ".lvlor"}, lvlOr,        rotl(INIT_PAT, mLevel));
    chk({tag, ".level"}, {4'd0, lvl},  8'(mLevel));
    chk({tag, ".busy"},  {7'd0, busy}, {7'd0, mBusy});
    chk({tag, ".win"},   {7'd0, win},  {7'd0, mWin});
    chk({tag, ".gover"}, {7'd0, gover},{7'd0, mGo});
  endtask

  task automatic modelReset();
    active = 0; initCycle = 0; mWin = 0; mGo = 0; mBusy = 0;
    mLevel = 0; pending = 0; mCmd = 4'b0000;
  endtask

  // One clock of game rules, applied to the inputs sampled at this edge.
  task automatic modelStep(input logic s, input logic l, input logic c);
    mCmd = 4'b0000;
    if (!active) begin
      if (!s) begin
        mCmd = 4'b0010; mLevel = 0; mGo = 0; mWin = 0;
        active = 1; initCycle = 1; pending = HOLD + 1; mBusy = 0;
      end
    end else if (c && !initCycle) begin
      mCmd = 4'b0010; mGo = 1; mLevel = 0; active = 0; mBusy = 0; pending = 0;
    end else if (pending == 0) begin
      if (l) begin
`ifdef SC_LEVELSEQ_WRAP_EN
        mLevel = (mLevel + 1) % (MAXL + 1);
        mCmd = 4'b0001; pending = HOLD + 1; mBusy = 1;
`else
        if (mLevel < MAXL) begin
          mLevel++; mCmd = 4'b0001; pending = HOLD + 1; mBusy = 1;
        end else begin
          mWin = 1; active = 0;
        end
`endif
      end
    end else begin
      pending--; initCycle = 0; mBusy = (pending > 0);
    end
  endtask

  task automatic step(input logic s, input logic l, input logic c, input string tag);
    startN = s; ld = l; cr = c;
    @(posedge clk);
    modelStep(s, l, c);
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic playToLevel(input int target);
    step(1'b0, 1'b0, 1'b0, "start");
    idle(HOLD + 1, "settle0");
    for (int k = 0; k < target; k++) begin
      step(1'b1, 1'b1, 1'b0, "adv");
      idle(HOLD + 1, "settleN");
    end
  endtask

  initial begin
    modelReset();
    #12;
    checkAll("reset_held");
    @(negedge clk);
    rst = 1'b0;

    // No command without START, even with stray pulses.
    step(1'b1, 1'b1, 1'b0, "idle_ld");
    step(1'b1, 1'b0, 1'b1, "idle_cr");
    idle(3, "idle");

    // Start: init command, 16 busy cycles, then play.
    step(1'b0, 1'b0, 1'b0, "init");
    chk("init_cmd", {4'd0, cmd}, 8'h02);
    idle(HOLD + 1, "settle_init");
    chk("play_busy", {7'd0, busy}, 8'h00);

    // First advance, then a LEVELDONE during SETTLE must be ignored.
    step(1'b1, 1'b1, 1'b0, "adv1");
    chk("adv1_lvlor", lvlOr, 8'b11001111);
    idle(4, "settle_adv1");
    step(1'b1, 1'b1, 1'b0, "ld_in_settle");
    chk("ld_in_settle_cmd", {4'd0, cmd}, 8'h00);
    idle(HOLD, "settle_adv1b");

    // Advance to the top level, then one more LEVELDONE.
    for (int k = 1; k < MAXL; k++) begin
      step(1'b1, 1'b1, 1'b0, "advN");
      idle(HOLD + 1, "settle_advN");
    end
    chk("top_lvlor", lvlOr, 8'b11110011);
    step(1'b1, 1'b1, 1'b0, "top_ld");
`ifdef SC_LEVELSEQ_WRAP_EN
    chk("wrap_cmd", {4'd0, cmd}, 8'h01);
    chk("wrap_lvlor", lvlOr, INIT_PAT);
    idle(HOLD + 1, "wrap_settle");
    step(1'b1, 1'b0, 1'b1, "wrap_crash");
`else
    chk("win_flag", {7'd0, win}, 8'h01);
    idle(2, "win_hold");
    step(1'b1, 1'b0, 1'b1, "win_crash_ignored");
`endif

    // Simultaneous crash and levelDone at level 3.
    step(1'b0, 1'b0, 1'b0, "restart");
    idle(HOLD + 1, "settle_r");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, "adv_to3");
      idle(HOLD + 1, "settle_to3");
    end
    step(1'b1, 1'b1, 1'b1, "crash_and_ld");
    chk("crash_cmd", {4'd0, cmd}, 8'h02);
    chk("crash_gover", {7'd0, gover}, 8'h01);

    // START held low continuously after a crash: exactly one init.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, "start_held");
    chk("start_held_gover", {7'd0, gover}, 8'h00);

    // Crash during an ADVANCE cycle: 0001 then 0010.
    step(1'b1, 1'b1, 1'b0, "adv_then_crash");
    step(1'b1, 1'b0, 1'b1, "crash_in_adv");
    chk("crash_in_adv_cmd", {4'd0, cmd}, 8'h02);
    idle(2, "post_crash");

    // Reset asserted mid-SETTLE at level 2.
    playToLevel(1);
    step(1'b1, 1'b1, 1'b0, "adv_to2");
    idle(5, "settle_l2");
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("async_reset");
    @(negedge clk);
    rst = 1'b0;
    idle(HOLD + 10, "after_reset");

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 59) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
